carry_select_subtractor8_pipe: RTL and testbench
================================================

// Module: carry_select_subtractor8_pipe
// PURPOSE
//  8-bit unsigned/two's-complement subtractor, diff = a - b - bin, built carry-select style:
//  low nibble ripple-borrow; high nibble precomputed for borrow-in 0 and 1, then selected.
//  Two-stage valid/ready pipeline, full throughput (1 op/cycle).
//  Companion to the carry_select_adder8 datapath: it sits where operands are subtracted.
// PARAMETERS
//  (none; width fixed at 8, split fixed at 4/4)
// PORTS
//  clk        in   1  clock, all state on rising edge
//  rst        in   1  asynchronous reset, active-high
//  a          in   8  minuend
//  b          in   8  subtrahend
//  bin        in   1  borrow in
//  in_valid   in   1  operands valid
//  in_ready   out  1  stage 1 can accept this cycle
//  diff       out  8  result (a - b - bin) mod 256
//  bout       out  1  borrow out: 1 iff a < b + bin (unsigned)
//  ovf        out  1  signed overflow: a[7]!=b[7] && diff[7]!=a[7]
//  out_valid  out  1  diff/bout/ovf valid
//  out_ready  in   1  consumer accepts result
// BEHAVIOUR
//  Reset values: out_valid=0, diff=8'h00, bout=0, ovf=0, internal s1_valid=0; in_ready=1 after reset.
//  Reset asserted mid-operation: both stages flushed immediately, in-flight ops discarded, never output.
//  Stage 1 (capture when in_valid && in_ready):
//   - lo = a[3:0]-b[3:0]-bin, 4 bits; b4 = borrow out of nibble 0.
//   - hi0 = a[7:4]-b[7:4], borrow bo0; hi1 = a[7:4]-b[7:4]-1, borrow bo1; register lo,b4,hi0,hi1,bo0,bo1,a[7],b[7].
//  Stage 2 (load when s1_valid && s2_can_load):
//   - diff = {b4 ? hi1 : hi0, lo}; bout = b4 ? bo1 : bo0; ovf per port definition.
//  Handshake:
//   - s2_can_load = !out_valid || out_ready; in_ready = !s1_valid || s2_can_load (comb, no skid buffer).
//   - Transfer on input side iff in_valid && in_ready; on output side iff out_valid && out_ready.
//   - out_valid clears on output transfer unless stage 2 reloads same cycle.
//   - While out_valid && !out_ready: diff/bout/ovf held stable, no stage-2 overwrite.
//   - in_valid ignored (no capture) when in_ready=0; inputs need not be held by producer beyond transfer cycle.
//  Latency: operand accepted at edge N -> result visible (out_valid=1) after edge N+1 with out_ready high.
//  Throughput: back-to-back inputs with out_ready=1 give out_valid=1 every cycle, order preserved.
//  Simultaneous in/out transfer on a full pipe: legal, both stages advance in one edge, no bubble.
//  Wrap: 8'h00-8'h01 -> 8'hFF, bout=1; bin=1 with a==b -> 8'hFF, bout=1.
//  No X propagation: stage data registers loaded only on transfer, reset to 0.
// TESTING
//  1. a=8'h5A,b=8'h23,bin=0 -> diff=8'h37,bout=0,ovf=0, out_valid 2 edges after accept.
//  2. a=8'h00,b=8'h01,bin=0 -> diff=8'hFF,bout=1,ovf=0; a=8'h10,b=8'h10,bin=1 -> 8'hFF,bout=1.
//  3. Nibble-borrow select: a=8'h30,b=8'h01,bin=0 -> 8'h2F (hi1 path); a=8'h80,b=8'h01 -> 8'h7F,ovf=1.
//  4. Stream 16 ops, out_ready=1 -> 16 results on consecutive cycles, in order, in_ready stays 1.
//  5. out_ready=0 for 5 cycles with 3 ops offered -> 2 held in pipe, in_ready=0, diff stable; release -> in-order drain.
//  6. rst pulsed with both stages full -> out_valid=0 asynchronously, held ops never emerge, in_ready=1 after.
//  Scoreboard: random a,b,bin, random out_ready/in_valid vs. reference model {bout,diff}=a-b-bin (9-bit).

Source files
------------

// File: rtl/carry_select_subtractor8_pipe.sv
// carry_select_subtractor8_pipe
// 8-bit subtractor diff = a - b - bin, built carry-select style.
// The low nibble ripples its borrow. The high nibble is computed twice, once
// assuming no borrow from the low nibble and once assuming a borrow, and the
// real nibble borrow picks between them. Two pipeline stages use a valid/ready
// handshake and can accept one operation every cycle.

module carry_select_subtractor8_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ovf,
    output logic       out_valid,
    input  logic       out_ready
);

    // Stage 1 registers: low nibble result plus both high-nibble candidates.
    logic       s1_valid;
    logic [3:0] s1_lo;
    logic       s1_b4;
    logic [3:0] s1_hi0;
    logic [3:0] s1_hi1;
    logic       s1_bo0;
    logic       s1_bo1;
    logic       s1_a7;
    logic       s1_b7;

    // Stage 1 combinational results.
    logic [3:0] lo_c;
    logic       b4_c;
    logic       br;
    logic [4:0] hi0_full;
    logic [4:0] hi1_full;

    // Stage 2 select results.
    logic [3:0] hi_sel;
    logic       bo_sel;
    logic [7:0] diff_c;
    logic       ovf_c;

    logic s2_can_load;
    logic in_xfer;

    // Handshake: stage 2 can load when it is empty or is draining this cycle.
    // Stage 1 can accept when it is empty or is moving into stage 2.
    always_comb begin
        s2_can_load = !out_valid || out_ready;
        in_ready    = !s1_valid || s2_can_load;
        in_xfer     = in_valid && in_ready;
    end

    // Low nibble: ripple the borrow one bit at a time, starting from bin.
    always_comb begin
        lo_c = 4'h0;
        br   = bin;
        for (int i = 0; i < 4; i++) begin
            lo_c[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        b4_c = br;
    end

    // High nibble candidates. Bit 4 of each 5-bit difference is the borrow.
    // The smallest value is -16, which still has bit 4 set.
    always_comb begin
        hi0_full = {1'b0, a[7:4]} - {1'b0, b[7:4]};
        hi1_full = hi0_full - 5'd1;
    end

    // Stage 2 select: the registered nibble borrow picks the high candidate.
    // Overflow means the operands had different signs and the result sign
    // differs from the minuend.
    always_comb begin
        hi_sel = s1_b4 ? s1_hi1 : s1_hi0;
        bo_sel = s1_b4 ? s1_bo1 : s1_bo0;
        diff_c = {hi_sel, s1_lo};
        ovf_c  = (s1_a7 != s1_b7) && (hi_sel[3] != s1_a7);
    end

    // Stage 1 capture. Data registers load only on an input transfer.
    // The valid bit clears once the operation moves into stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lo    <= 4'h0;
            s1_b4    <= 1'b0;
            s1_hi0   <= 4'h0;
            s1_hi1   <= 4'h0;
            s1_bo0   <= 1'b0;
            s1_bo1   <= 1'b0;
            s1_a7    <= 1'b0;
            s1_b7    <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_lo    <= lo_c;
            s1_b4    <= b4_c;
            s1_hi0   <= hi0_full[3:0];
            s1_hi1   <= hi1_full[3:0];
            s1_bo0   <= hi0_full[4];
            s1_bo1   <= hi1_full[4];
            s1_a7    <= a[7];
            s1_b7    <= b[7];
        end else if (s2_can_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 output register. While the consumer stalls, the outputs hold.
    // Otherwise out_valid takes on whatever stage 1 holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= 8'h00;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_can_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                diff <= diff_c;
                bout <= bo_sel;
                ovf  <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_carry_select_subtractor8_pipe.sv
// tb_carry_select_subtractor8_pipe
// Directed and random stimulus for carry_select_subtractor8_pipe. The
// reference model is a FIFO of expected results computed with plain integer
// arithmetic. Each entry also records the clock edge at which it was accepted.

module tb_carry_select_subtractor8_pipe;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         t;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    carry_select_subtractor8_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build the expected result from signed and unsigned integer arithmetic.
    function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input int t);
        exp_t e;
        int   r;
        int   sr;
        r    = int'(ia) - int'(ib) - int'(ibin);
        sr   = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
        e.d  = r[7:0];
        e.bo = (r < 0);
        e.ov = (sr > 127) || (sr < -128);
        e.t  = t;
        return e;
    endfunction

    // Called at a falling edge. It checks the outputs against the model,
    // drives one cycle of inputs, updates the model, and steps to the next
    // falling edge.
    task automatic applyStimulus(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                                 input logic ibin, input logic ordy);
        logic exp_ov;
        logic exp_rdy;
        exp_ov = (q.size() > 0) && ((cyc - q[0].t) >= 1);
        checkOutput("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            checkOutput("diff", diff, q[0].d);
            checkOutput("bout", bout, q[0].bo);
            checkOutput("ovf", ovf, q[0].ov);
        end
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        #1;
        exp_rdy = !((q.size() == 2) && !ordy);
        checkOutput("in_ready", in_ready, exp_rdy);
        if (exp_ov && ordy) void'(q.pop_front());
        if (iv && exp_rdy) q.push_back(model(ia, ib, ibin, cyc + 1));
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Run one operation through an otherwise empty pipe. Two edges after
    // acceptance, check the result against the given constants.
    task automatic directedOp(input string tag, input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                              input logic [7:0] ed, input logic ebo, input logic eov);
        applyStimulus(1'b1, ia, ib, ibin, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput({tag, "_valid"}, out_valid, 1'b1);
        checkOutput({tag, "_diff"}, diff, ed);
        checkOutput({tag, "_bout"}, bout, ebo);
        checkOutput({tag, "_ovf"}, ovf, eov);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    // Idle with out_ready high until the model is empty, within a cycle budget.
    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++)
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("drain_empty", q.size(), 0);
    endtask

    // The whole test sequence is a single linear series of directed steps.
    initial begin
        rst       = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        bin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_diff", diff, 8'h00);
        checkOutput("rst_bout", bout, 1'b0);
        checkOutput("rst_ovf", ovf, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Basic subtraction, wrap cases, and both high-nibble select paths.
        directedOp("t1", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        directedOp("t2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        directedOp("t2b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        directedOp("t3a", 8'h30, 8'h01, 1'b0, 8'h2F, 1'b0, 1'b0);
        directedOp("t3b", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        // Sixteen back-to-back operations with the consumer always ready.
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        drain();

        // Consumer stalls while three operations are offered: two fill the pipe.
        applyStimulus(1'b1, 8'h44, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h09, 8'h0A, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 8'hC3, 8'h3C, 1'b0, 1'b0);
        checkOutput("t5_in_ready", in_ready, 1'b0);
        checkOutput("t5_diff_held", diff, 8'h33);
        checkOutput("t5_held_count", q.size(), 2);
        drain();

        // Asynchronous reset with both stages full discards both operations.
        applyStimulus(1'b1, 8'h77, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h66, 8'h33, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("t6_full", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("t6_async_out_valid", out_valid, 1'b0);
        checkOutput("t6_in_ready", in_ready, 1'b1);
        q.delete();
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Random traffic with random backpressure against the model.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) != 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
